// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate-level response checker.
// Truth tables are indexed by the stimulus vector {a,b}.
package gate_chk_pkg;

  localparam int CNT_W = 8;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VEC = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_COMPARE  = 3'd3,
    ST_DONE     = 3'd4
  } chk_state_t;

  function automatic logic tt_lookup(input logic [3:0] truth, input logic [1:0] vec);
    return truth[vec];
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gate_resp_checker.sv
// Compares a gate DUT's output against a truth table a fixed settle time after each
// applied vector; counts checks/errors, flags overruns and reports a per-run verdict.
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0]  TRUTH   = TT_AND,
  parameter int unsigned SETTLE  = 3,
  parameter int unsigned NUM_VEC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             a,
  input  logic             b,
  input  logic             out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_valid,
  output logic             overrun
);

  if (SETTLE < 2 || SETTLE > 15) begin : g_bad_settle
    $error("gate_resp_checker: SETTLE must be within 2..15");
  end
  if (NUM_VEC < 1 || NUM_VEC > 255) begin : g_bad_num_vec
    $error("gate_resp_checker: NUM_VEC must be within 1..255");
  end

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] NUM_VEC_C   = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  chk_state_t       state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [1:0]       ffv_q, ffv_d;
  logic             ffval_q, ffval_d;
  logic             ovr_q, ovr_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;

  logic             out_sync;
  logic             mismatch;
  logic [CNT_W-1:0] chk_inc;

  sync2 u_out_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (out),
    .q_o   (out_sync)
  );

  assign chk_inc = chk_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    chk_d    = chk_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffval_d  = ffval_q;
    ovr_d    = ovr_q;
    pass_d   = pass_q;
    busy_d   = busy_q;
    mismatch = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT_VEC;
          chk_d   = '0;
          err_d   = '0;
          ffv_d   = 2'b00;
          ffval_d = 1'b0;
          ovr_d   = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_WAIT_VEC: begin
        if (vec_valid) begin
          vec_d    = {a, b};
          settle_d = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        // A vector arriving mid-settle replaces the pending one and restarts the window.
        if (vec_valid) begin
          vec_d    = {a, b};
          settle_d = SETTLE_LOAD;
          ovr_d    = 1'b1;
        end else if (settle_q == 4'd0) begin
          state_d = ST_COMPARE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      ST_COMPARE: begin
        mismatch = (out_sync != tt_lookup(TRUTH, vec_q));
        chk_d    = chk_inc;
        if (mismatch) begin
          if (err_q != CNT_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!ffval_q) begin
            ffv_d   = vec_q;
            ffval_d = 1'b1;
          end
        end

        if (chk_inc == NUM_VEC_C) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0) && !ovr_q;
        end else if (vec_valid) begin
          // Back-to-back vector lands on the compare cycle: accept it without overrun.
          vec_d    = {a, b};
          settle_d = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end else begin
          state_d = ST_WAIT_VEC;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= 2'b00;
      settle_q <= 4'd0;
      chk_q    <= '0;
      err_q    <= '0;
      ffv_q    <= 2'b00;
      ffval_q  <= 1'b0;
      ovr_q    <= 1'b0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffval_q  <= ffval_d;
      ovr_q    <= ovr_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
    end
  end

  assign busy             = busy_q;
  assign done             = (state_q == ST_DONE);
  assign pass             = pass_q;
  assign chk_cnt          = chk_q;
  assign err_cnt          = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;
  assign overrun          = ovr_q;

endmodule

// File: doc/gate_resp_checker.md
# gate_resp_checker

Synthesizable response checker for two-input gate-level DUTs. It receives each applied `{a,b}` stimulus vector and the DUT's `out`. After a programmable settle window it compares `out` with a parameterized truth table, then counts checks, errors and overruns. It sits at the output side of the gate-level test harness and replaces `$monitor`-style eyeballing with a pass/fail verdict usable in simulation and on hardware.

## Interface
- `TRUTH`, 4'b1000, expected `out` indexed by `{a,b}`; the default is AND.
- `SETTLE`, 3, cycles from `vec_valid` to compare. Legal range is 2..15; the synthesized `out` path needs at least 2 cycles.
- `NUM_VEC`, 4, compares per run before `done`. Legal range is 1..255.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a run.
- `vec_valid`  in  1  a new `{a,b}` is applied to the DUT this cycle.
- `a`, `b`  in  1 each  stimulus bits, sampled when `vec_valid`=1.
- `out`  in  1  DUT output, asynchronous to `clk`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  last run had `err_cnt`==0 and `overrun`==0; held until the next `start`.
- `chk_cnt`  out  8  compares completed this run.
- `err_cnt`  out  8  mismatches this run; saturates at 255.
- `first_fail_vec`  out  2  `{a,b}` of the first mismatch.
- `first_fail_valid`  out  1  `first_fail_vec` is meaningful.
- `overrun`  out  1  sticky; a vector arrived before the previous compare.

## Operation
- All outputs reset to 0.
- FSM states: IDLE, WAIT_VEC, SETTLE, COMPARE, DONE.
- IDLE: `start` → WAIT_VEC. This clears `chk_cnt`, `err_cnt`, `first_fail_*`, `overrun` and `pass`, and sets `busy`=1.
- WAIT_VEC: `vec_valid` → latch `{a,b}`, load the settle counter with `SETTLE-1`, go to SETTLE.
- SETTLE:
  - Counter decrements each cycle; at 0 → COMPARE.
  - `vec_valid` in SETTLE: discard the pending vector, latch the new one, reload the counter, set `overrun`. The discarded vector is not counted.
- COMPARE (one cycle):
  - Compute `mismatch` = synchronized `out` != `TRUTH[{a,b}]`.
  - `chk_cnt`+1.
  - On mismatch: `err_cnt`+1 (saturating). If `first_fail_valid`=0, capture the vector and set `first_fail_valid`.
  - If the new `chk_cnt`==`NUM_VEC` → DONE, else → WAIT_VEC.
  - `vec_valid` in COMPARE: the current compare completes, the new vector is latched, and the next state is SETTLE (not WAIT_VEC). If the run finished, the vector is ignored.
- DONE (one cycle): `done`=1, `busy`=0, `pass` = (`err_cnt`==0 && !`overrun`), then → IDLE.
- `start` while `busy`=1 is ignored. `start` in DONE is ignored; it is accepted in the next cycle (IDLE).
- `vec_valid` in IDLE or DONE is ignored and does not set `overrun`.
- `rst_n` low at any time: asynchronous return to IDLE, all outputs 0, and any in-flight compare is lost.

## Timing
- `out` passes through a 2-flop synchronizer before comparison.
- Cycle of `vec_valid` = t:
  - compare occurs at edge t+SETTLE;
  - `chk_cnt`/`err_cnt` update is visible at t+SETTLE+1.
- `done` rises on the cycle after the final counter update and lasts exactly one cycle.
- Back-to-back vectors spaced exactly SETTLE+1 cycles apart produce no overrun.
- Minimum run length from `start` to `done` = `NUM_VEC`×(SETTLE+1)+2 cycles.
- Asynchronous assert of `rst_n`; release is synchronous to `clk` (the harness supplies a synchronized deassert).

## Structure
- Package `gate_chk_pkg` holds:
  - the state enum `chk_state_t`;
  - truth constants `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_XOR`=4'b0110, `TT_NAND`=4'b0111, `TT_NOR`=4'b0001;
  - `CNT_W`=8.
- Sub-module `sync2`: 2-flop synchronizer with async active-low reset to 0, used for `out`.
- Top-level FSM, settle counter and the counters live in `gate_resp_checker`.

## Test plan
- AND DUT, `TRUTH`=`TT_AND`, `SETTLE`=3, `start`, then vectors 00, 01, 10, 11 every 4 cycles → `chk_cnt`=4, `err_cnt`=0, `pass`=1, `done` one cycle.
- `out` forced to 0 for vector 11, all others correct → `err_cnt`=1, `first_fail_vec`=2'b11, `first_fail_valid`=1, `pass`=0.
- Second `vec_valid` 1 cycle after the first → `overrun`=1, `chk_cnt` advances by 1 for that pair, `pass`=0 even with `err_cnt`=0.
- `rst_n` pulsed low mid-SETTLE of vector 2 → all outputs 0 immediately, `busy`=0. A later `start` runs cleanly to `pass`=1.
- `start` pulsed during SETTLE → ignored, counters not cleared, run completes normally.
- `NUM_VEC`=255 with `out` always wrong → `err_cnt`=255 with no wrap, `first_fail_vec` = the first vector applied.
